// File: rtl/board_state_writer.sv
// rtl/board_state_writer.sv - game board scrambler and move applier feeding the win checker
//
// Scrambles a fresh board from a 16-bit LFSR, then applies cursor moves and
// three-cell flips from button edges. Freezes once the checker reports a win.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   BtnLeft/BtnRight  rising edge moves the cursor down/up by one (wraps)
//   BtnFlip           rising edge toggles cells cursor-1, cursor, cursor+1
//   NewGame           rising edge in PLAY/WON starts a new scramble
//   Win               checker Buzz, one cycle behind ScreenValues
//   ScreenValues      board register
//   Cursor            current cursor cell
//   Busy              scrambling or settling
//   Won               board frozen on a win
//   MoveCount         flips this game, saturating
module board_state_writer #(
    parameter int          NumberOfBits  = 31,
    parameter int          CursorBits    = 5,
    parameter int          ScrambleSteps = 24,
    parameter logic [15:0] Seed          = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    BtnLeft,
    input  logic                    BtnRight,
    input  logic                    BtnFlip,
    input  logic                    NewGame,
    input  logic                    Win,
    output logic [NumberOfBits:0]   ScreenValues,
    output logic [CursorBits-1:0]   Cursor,
    output logic                    Busy,
    output logic                    Won,
    output logic [15:0]             MoveCount
);

    localparam int                    W            = NumberOfBits + 1;
    localparam logic [15:0]           SEED_EFF     = (Seed == 16'h0000) ? 16'h0001 : Seed;
    localparam logic [15:0]           STEPS_TARGET = 16'(ScrambleSteps);
    localparam logic [CursorBits-1:0] CUR_ONE      = {{(CursorBits-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_SCRAMBLE = 2'd0,
        S_SETTLE   = 2'd1,
        S_PLAY     = 2'd2,
        S_WON      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          board_q, board_d;
    logic [CursorBits-1:0] cursor_q, cursor_d;
    logic [15:0]           moves_q, moves_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [15:0]           steps_q, steps_d;
    // {NewGame, BtnFlip, BtnRight, BtnLeft}
    logic [3:0]            prev_q;
    logic [3:0]            btn_now;
    logic [3:0]            btn_edge;

    // Cursor width equals log2 of the board width, so plain modular
    // arithmetic on the index gives the wrap-around neighbours.
    function automatic logic [W-1:0] flip_mask(input logic [CursorBits-1:0] p);
        logic [W-1:0]          m;
        logic [CursorBits-1:0] lo;
        logic [CursorBits-1:0] hi;
        lo    = p - CUR_ONE;
        hi    = p + CUR_ONE;
        m     = '0;
        m[p]  = 1'b1;
        m[lo] = 1'b1;
        m[hi] = 1'b1;
        return m;
    endfunction

    function automatic logic is_win_pattern(input logic [W-1:0] b);
        return (b == '0) || (b == '1) ||
               (b == {(W/2){2'b01}}) || (b == {(W/2){2'b10}});
    endfunction

    // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    assign btn_now  = {NewGame, BtnFlip, BtnRight, BtnLeft};
    assign btn_edge = btn_now & ~prev_q;

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        cursor_d = cursor_q;
        moves_d  = moves_q;
        lfsr_d   = lfsr_q;
        steps_d  = steps_q;
        case (state_q)
            S_SCRAMBLE: begin
                board_d = board_q ^ flip_mask(lfsr_q[CursorBits-1:0]);
                lfsr_d  = lfsr_next(lfsr_q);
                steps_d = (steps_q == 16'hFFFF) ? steps_q : steps_q + 16'd1;
                // A board that already shows a win would buzz immediately,
                // so keep stepping until it does not.
                if ((steps_d >= STEPS_TARGET) && !is_win_pattern(board_d)) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (btn_edge[3]) begin
                    state_d = S_SCRAMBLE;
                    board_d = '0;
                    moves_d = '0;
                    steps_d = '0;
                end else begin
                    if (btn_edge[2]) begin
                        board_d = board_q ^ flip_mask(cursor_q);
                        moves_d = (moves_q == 16'hFFFF) ? moves_q : moves_q + 16'd1;
                    end
                    if (btn_edge[0] && !btn_edge[1]) begin
                        cursor_d = cursor_q - CUR_ONE;
                    end else if (btn_edge[1] && !btn_edge[0]) begin
                        cursor_d = cursor_q + CUR_ONE;
                    end
                    if (Win) begin
                        state_d = S_WON;
                    end
                end
            end
            S_WON: begin
                if (btn_edge[3]) begin
                    state_d = S_SCRAMBLE;
                    board_d = '0;
                    moves_d = '0;
                    steps_d = '0;
                end
            end
            default: begin
                state_d = S_SCRAMBLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_SCRAMBLE;
            board_q  <= '0;
            cursor_q <= '0;
            moves_q  <= '0;
            lfsr_q   <= SEED_EFF;
            steps_q  <= '0;
            // Held buttons must not register as a press after reset.
            prev_q   <= '1;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            cursor_q <= cursor_d;
            moves_q  <= moves_d;
            lfsr_q   <= lfsr_d;
            steps_q  <= steps_d;
            prev_q   <= btn_now;
        end
    end

    assign ScreenValues = board_q;
    assign Cursor       = cursor_q;
    assign MoveCount    = moves_q;
    assign Busy         = (state_q == S_SCRAMBLE) || (state_q == S_SETTLE);
    assign Won          = (state_q == S_WON);

endmodule

// File: tb/tb_board_state_writer.sv
// tb/tb_board_state_writer.sv - self-checking bench for board_state_writer
module tb_board_state_writer;

    localparam int          NB   = 31;
    localparam int          CB   = 5;
    localparam int          SS   = 1;
    localparam logic [15:0] SEED = 16'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        BtnLeft, BtnRight, BtnFlip, NewGame, Win;
    logic [31:0] ScreenValues;
    logic [4:0]  Cursor;
    logic        Busy, Won;
    logic [15:0] MoveCount;

    always #5 clk = ~clk;

    board_state_writer #(
        .NumberOfBits (NB),
        .CursorBits   (CB),
        .ScrambleSteps(SS),
        .Seed         (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .BtnLeft     (BtnLeft),
        .BtnRight    (BtnRight),
        .BtnFlip     (BtnFlip),
        .NewGame     (NewGame),
        .Win         (Win),
        .ScreenValues(ScreenValues),
        .Cursor      (Cursor),
        .Busy        (Busy),
        .Won         (Won),
        .MoveCount   (MoveCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_win(input logic [31:0] b);
        return (b == 32'h0) || (b == 32'hFFFF_FFFF) ||
               (b == 32'h5555_5555) || (b == 32'hAAAA_AAAA);
    endfunction

    // Reference model: board as bit vector, cursor as integer, game phase as
    // a small integer (0 scramble, 1 settle, 2 play, 3 won).
    logic [31:0] m_board;
    int          m_cur;
    int          m_moves;
    logic [15:0] m_lfsr;
    int          m_steps;
    int          m_phase;
    bit          m_prev_l, m_prev_r, m_prev_f, m_prev_n;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] toggle3(input logic [31:0] b, input int p);
        logic [31:0] r;
        r = b;
        for (int k = -1; k <= 1; k++) begin
            r[(p + k + 32) % 32] = ~r[(p + k + 32) % 32];
        end
        return r;
    endfunction

    task automatic model_step();
        bit el, er, ef, en;
        m_valid = 1'b1;
        if (reset) begin
            m_board = 32'h0;
            m_cur   = 0;
            m_moves = 0;
            m_lfsr  = (SEED == 16'h0) ? 16'h1 : SEED;
            m_steps = 0;
            m_phase = 0;
            m_prev_l = 1'b1; m_prev_r = 1'b1; m_prev_f = 1'b1; m_prev_n = 1'b1;
            return;
        end
        el = BtnLeft  && !m_prev_l;
        er = BtnRight && !m_prev_r;
        ef = BtnFlip  && !m_prev_f;
        en = NewGame  && !m_prev_n;
        m_prev_l = BtnLeft; m_prev_r = BtnRight; m_prev_f = BtnFlip; m_prev_n = NewGame;
        if (m_phase == 0) begin
            m_board = toggle3(m_board, int'(m_lfsr % 16'd32));
            m_lfsr  = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
            m_steps = m_steps + 1;
            if (m_steps >= SS && !is_win(m_board)) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (en) begin
            m_phase = 0;
            m_board = 32'h0;
            m_moves = 0;
            m_steps = 0;
        end else if (m_phase == 2) begin
            if (ef) begin
                m_board = toggle3(m_board, m_cur);
                if (m_moves < 65535) m_moves = m_moves + 1;
            end
            if (el && !er) m_cur = (m_cur + 31) % 32;
            if (er && !el) m_cur = (m_cur + 1) % 32;
            if (Win) m_phase = 3;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_board",  ScreenValues,     m_board);
            check("model_cursor", {27'h0, Cursor},  m_cur);
            check("model_busy",   {31'h0, Busy},    (m_phase <= 1) ? 1 : 0);
            check("model_won",    {31'h0, Won},     (m_phase == 3) ? 1 : 0);
            check("model_moves",  {16'h0, MoveCount}, m_moves);
        end
    end

    task automatic press(input bit l, input bit r, input bit f, input bit n);
        BtnLeft = l; BtnRight = r; BtnFlip = f; NewGame = n;
        @(negedge clk);
        BtnLeft = 0; BtnRight = 0; BtnFlip = 0; NewGame = 0;
        @(negedge clk);
    endtask

    task automatic wait_play(input string name);
        int n;
        n = 0;
        while (Busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'h0, (n < 200)}, 32'd1);
        check({name, "_nonwin"},  {31'h0, is_win(ScreenValues)}, 32'd0);
    endtask

    initial begin
        reset = 1; BtnLeft = 0; BtnRight = 0; BtnFlip = 0; NewGame = 0; Win = 0;
        repeat (3) @(negedge clk);
        check("rst_board", ScreenValues, 32'h0);
        check("rst_busy",  {31'h0, Busy}, 32'd1);
        check("rst_won",   {31'h0, Won},  32'd0);

        reset = 0;
        @(negedge clk);
        check("scr_board", ScreenValues, 32'h0000_0007);
        check("scr_busy",  {31'h0, Busy}, 32'd1);
        @(negedge clk);
        check("play_busy",   {31'h0, Busy}, 32'd0);
        check("play_cursor", {27'h0, Cursor}, 32'd0);
        check("play_moves",  {16'h0, MoveCount}, 32'd0);

        press(0, 0, 1, 0);
        check("flip_wrap_board", ScreenValues, 32'h8000_0004);
        check("flip_wrap_moves", {16'h0, MoveCount}, 32'd1);

        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        check("left2_cursor", {27'h0, Cursor}, 32'd30);

        press(1, 1, 0, 0);
        check("lr_cancel", {27'h0, Cursor}, 32'd30);

        BtnRight = 1;
        repeat (10) @(negedge clk);
        BtnRight = 0;
        @(negedge clk);
        check("hold_right", {27'h0, Cursor}, 32'd31);

        press(1, 0, 1, 0);
        check("flip_move_board",  ScreenValues, 32'h4000_0005);
        check("flip_move_cursor", {27'h0, Cursor}, 32'd30);
        check("flip_move_moves",  {16'h0, MoveCount}, 32'd2);

        Win = 1; BtnRight = 1;
        @(negedge clk);
        check("win_won",    {31'h0, Won}, 32'd1);
        check("win_cursor", {27'h0, Cursor}, 32'd31);
        Win = 0; BtnRight = 0;
        @(negedge clk);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        check("frozen_board",  ScreenValues, 32'h4000_0005);
        check("frozen_cursor", {27'h0, Cursor}, 32'd31);
        check("frozen_moves",  {16'h0, MoveCount}, 32'd2);
        check("frozen_won",    {31'h0, Won}, 32'd1);

        NewGame = 1;
        @(negedge clk);
        NewGame = 0;
        check("ng_won",    {31'h0, Won}, 32'd0);
        check("ng_busy",   {31'h0, Busy}, 32'd1);
        check("ng_board",  ScreenValues, 32'h0);
        check("ng_moves",  {16'h0, MoveCount}, 32'd0);
        check("ng_cursor", {27'h0, Cursor}, 32'd31);
        wait_play("ng1");

        NewGame = 1; Win = 1; BtnFlip = 1;
        @(negedge clk);
        NewGame = 0; Win = 0; BtnFlip = 0;
        check("ng_prio_won",   {31'h0, Won}, 32'd0);
        check("ng_prio_busy",  {31'h0, Busy}, 32'd1);
        check("ng_prio_board", ScreenValues, 32'h0);
        wait_play("ng2");

        NewGame = 1;
        @(negedge clk);
        NewGame = 0;
        reset = 1; BtnFlip = 1;
        repeat (2) @(negedge clk);
        check("mid_rst_board",  ScreenValues, 32'h0);
        check("mid_rst_cursor", {27'h0, Cursor}, 32'd0);
        reset = 0;
        @(negedge clk);
        check("reseed_board", ScreenValues, 32'h0000_0007);
        repeat (4) @(negedge clk);
        check("held_flip_board", ScreenValues, 32'h0000_0007);
        check("held_flip_moves", {16'h0, MoveCount}, 32'd0);
        check("held_flip_busy",  {31'h0, Busy}, 32'd0);
        BtnFlip = 0;
        @(negedge clk);
        press(0, 0, 1, 0);
        check("reflip_board", ScreenValues, 32'h8000_0004);
        check("reflip_moves", {16'h0, MoveCount}, 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
